// File: rtl/key_expansion_seq_pkg.sv
// key_expansion_seq_pkg: shared encodings, lookups and helpers for the AES key schedule
package key_expansion_seq_pkg;
   typedef enum logic [1:0] {KS_128, KS_192, KS_256, KS_ILLEGAL} key_size_e;
   typedef enum logic [1:0] {S_IDLE, S_GEN, S_DONE} state_e;
   localparam int WCNT_W = 6;
   localparam logic [3:0] NK_256 = 4'd8;
   function automatic logic [3:0] nk_of(input logic [1:0] ks);
      return ks == KS_128 ? 4'd4 : ks == KS_192 ? 4'd6 : ks == KS_256 ? NK_256 : 4'd0;
   endfunction
   function automatic logic [3:0] nr_of(input logic [1:0] ks);
      return ks == KS_128 ? 4'd10 : ks == KS_192 ? 4'd12 : ks == KS_256 ? 4'd14 : 4'd0;
   endfunction
   function automatic logic [7:0] xtime(input logic [7:0] r);
      return {r[6:0], 1'b0} ^ (r[7] ? 8'h1b : 8'h00);
   endfunction
endpackage

// File: rtl/key_expansion_seq_if.sv
// key_expansion_seq_if: control and round-key read bus of the key schedule
interface key_expansion_seq_if;
   logic         start;
   logic [1:0]   keySize;
   logic [255:0] keyIn;
   logic         ready;
   logic         busy;
   logic         keysValid;
   logic         err;
   logic [3:0]   numRounds;
   logic [3:0]   roundIdx;
   logic [127:0] roundKey;
   logic         roundKeyValid;
   modport master (output start, keySize, keyIn, roundIdx,
                   input ready, busy, keysValid, err, numRounds, roundKey, roundKeyValid);
   modport slave (input start, keySize, keyIn, roundIdx,
                  output ready, busy, keysValid, err, numRounds, roundKey, roundKeyValid);
endinterface

// File: rtl/key_expansion_seq_sbox.sv
// aes_sbox: AES forward S-box as a 256-byte constant table
module aes_sbox (
   input  logic [7:0] din,
   output logic [7:0] dout
);
   localparam logic [2047:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
   assign dout = SBOX[8 * (255 - int'(din)) +: 8];
endmodule

// File: rtl/key_expansion_seq_word_gen.sv
// key_word_gen: computes one expanded key word from w[i-1], w[i-Nk], phase and rcon
module key_word_gen
   import key_expansion_seq_pkg::*;
(
   input  logic [31:0] prevWord,
   input  logic [31:0] nkAgoWord,
   input  logic [2:0]  phase,
   input  logic [3:0]  nk,
   input  logic [7:0]  rcon,
   output logic [31:0] newWord
);
   logic [31:0] sub_in, sub_out, temp;
   assign sub_in = phase == 3'd0 ? {prevWord[23:0], prevWord[31:24]} : prevWord;
   for (genvar b = 0; b < 4; b++) begin : g_sb
      aes_sbox u_sbox (.din(sub_in[8*b +: 8]), .dout(sub_out[8*b +: 8]));
   end
   assign temp = phase == 3'd0 ? sub_out ^ {rcon, 24'h0}
               : (nk == NK_256 && phase == 3'd4) ? sub_out : prevWord;
   assign newWord = nkAgoWord ^ temp;
endmodule

// File: rtl/key_expansion_seq.sv
// key_expansion_seq: run-time selectable AES key schedule, one word per clock, indexed round-key read
module key_expansion_seq
   import key_expansion_seq_pkg::*;
#(
   parameter int MAX_KEY_BITS = 256,
   parameter bit READ_REG     = 1'b0
) (
   input logic               clk,
   input logic               rstN,
   key_expansion_seq_if.slave bus
);
   localparam int DEPTH = MAX_KEY_BITS == 128 ? 44 : MAX_KEY_BITS == 192 ? 52 : 60;
   logic [31:0] mem_q [DEPTH];
   state_e state_q, state_d;
   logic [WCNT_W-1:0] wcnt_q, wcnt_d, end_cnt, base;
   logic [2:0] phase_q, phase_d;
   logic [7:0] rcon_q, rcon_d;
   logic [3:0] nk_q, nk_d, nr_q, nr_d, req_nk, req_nr;
   logic ready_q, ready_d, busy_q, busy_d, kv_q, kv_d, err_q, err_d;
   logic legal, accept, reject, gen_we, rkv_d;
   logic [31:0] new_word;
   logic [127:0] rk_d;
   assign req_nk  = nk_of(bus.keySize);
   assign req_nr  = nr_of(bus.keySize);
   assign legal   = bus.keySize != KS_ILLEGAL && int'(req_nk) * 32 <= MAX_KEY_BITS;
   assign accept  = bus.start && ready_q && legal;
   assign reject  = bus.start && ready_q && !legal;
   assign end_cnt = {nr_q, 2'b00} + WCNT_W'(4);
   // after the last word the FSM spends one GEN cycle with no write before DONE
   assign gen_we  = state_q == S_GEN && wcnt_q != end_cnt;
   key_word_gen u_gen (
      .prevWord (mem_q[wcnt_q - WCNT_W'(1)]),
      .nkAgoWord(mem_q[wcnt_q - WCNT_W'(nk_q)]),
      .phase    (phase_q),
      .nk       (nk_q),
      .rcon     (rcon_q),
      .newWord  (new_word)
   );
   always_comb begin
      state_d = state_q;
      wcnt_d  = wcnt_q;
      phase_d = phase_q;
      rcon_d  = rcon_q;
      nk_d    = nk_q;
      nr_d    = nr_q;
      kv_d    = kv_q;
      if (accept) begin
         state_d = S_GEN;
         wcnt_d  = WCNT_W'(req_nk);
         phase_d = 3'd0;
         rcon_d  = 8'h01;
         nk_d    = req_nk;
         nr_d    = req_nr;
         kv_d    = 1'b0;
      end else if (gen_we) begin
         wcnt_d  = wcnt_q + WCNT_W'(1);
         phase_d = {1'b0, phase_q} == nk_q - 4'd1 ? 3'd0 : phase_q + 3'd1;
         rcon_d  = phase_q == 3'd0 ? xtime(rcon_q) : rcon_q;
      end else if (state_q == S_GEN) begin
         state_d = S_DONE;
         kv_d    = 1'b1;
      end
      ready_d = state_d != S_GEN;
      busy_d  = state_d == S_GEN;
      err_d   = reject;
   end
   always_ff @(posedge clk) begin
      if (!rstN) begin
         state_q <= S_IDLE;
         wcnt_q  <= '0;
         phase_q <= '0;
         rcon_q  <= '0;
         nk_q    <= '0;
         nr_q    <= '0;
         ready_q <= 1'b1;
         busy_q  <= 1'b0;
         kv_q    <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         wcnt_q  <= wcnt_d;
         phase_q <= phase_d;
         rcon_q  <= rcon_d;
         nk_q    <= nk_d;
         nr_q    <= nr_d;
         ready_q <= ready_d;
         busy_q  <= busy_d;
         kv_q    <= kv_d;
         err_q   <= err_d;
      end
   end
   always_ff @(posedge clk) begin
      if (accept) begin
         for (int k = 0; k < 8; k++)
            if (k < int'(req_nk) && k < DEPTH) mem_q[k] <= bus.keyIn[255 - 32*k -: 32];
      end else if (gen_we) begin
         mem_q[wcnt_q] <= new_word;
      end
   end
   assign base  = {bus.roundIdx, 2'b00};
   // validity gates the storage read so unwritten words never reach the port
   assign rkv_d = bus.roundIdx <= nr_q && {1'b0, wcnt_q} >= {1'b0, base} + 7'd4;
   assign rk_d  = rkv_d ? {mem_q[base], mem_q[base + WCNT_W'(1)], mem_q[base + WCNT_W'(2)],
                           mem_q[base + WCNT_W'(3)]} : '0;
   if (READ_REG) begin : g_reg
      logic [127:0] rk_q;
      logic         rkv_q;
      always_ff @(posedge clk) begin
         if (!rstN) begin
            rk_q  <= '0;
            rkv_q <= 1'b0;
         end else begin
            rk_q  <= rk_d;
            rkv_q <= rkv_d;
         end
      end
      assign bus.roundKey      = rk_q;
      assign bus.roundKeyValid = rkv_q;
   end else begin : g_comb
      assign bus.roundKey      = rk_d;
      assign bus.roundKeyValid = rkv_d;
   end
   assign bus.ready     = ready_q;
   assign bus.busy      = busy_q;
   assign bus.keysValid = kv_q;
   assign bus.err       = err_q;
   assign bus.numRounds = nr_q;
endmodule

// File: tb/tb_key_expansion_seq.sv
// tb_key_expansion_seq: directed vector table plus hand sequences against FIPS-197 key schedules
module tb_key_expansion_seq;
   logic clk = 1'b0;
   logic rstN;
   always #5 clk = ~clk;
   key_expansion_seq_if bus();
   key_expansion_seq #(.MAX_KEY_BITS(256), .READ_REG(1'b0)) dut (.clk(clk), .rstN(rstN), .bus(bus));
   int checks = 0;
   int failures = 0;
   typedef struct {
      logic [1:0]   ks;
      logic [255:0] key;
      logic [3:0]   ridx;
      logic [127:0] rk;
      int           lat;
      logic [3:0]   nr;
   } vec_t;
   vec_t vecs[7];
   localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'ha5a5a5a5_5a5a5a5a_ffffffff_12345678};
   localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'hdeadbeef_cafef00d};
   localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
   localparam logic [127:0] R128_10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", nm, got, exp);
      end
   endtask
   task automatic run(input logic [1:0] ks, input logic [255:0] key, output int lat);
      bus.keySize = ks;
      bus.keyIn   = key;
      bus.start   = 1'b1;
      tick();
      bus.start = 1'b0;
      bus.keyIn = ~key;
      lat = 0;
      while (!bus.keysValid && lat < 200) begin
         tick();
         lat++;
      end
   endtask
   initial begin
      int lat, n, hits;
      vecs[0] = '{2'd0, K128, 4'd1,  128'ha0fafe1788542cb123a339392a6c7605, 41, 4'd10};
      vecs[1] = '{2'd0, K128, 4'd10, R128_10, 41, 4'd10};
      vecs[2] = '{2'd1, K192, 4'd12, 128'he98ba06f448c773c8ecc720401002202, 47, 4'd12};
      vecs[3] = '{2'd2, K256, 4'd14, 128'hfe4890d1e6188d0b046df344706c631e, 53, 4'd14};
      vecs[4] = '{2'd0, K128, 4'd0,  128'h2b7e151628aed2a6abf7158809cf4f3c, 41, 4'd10};
      vecs[5] = '{2'd2, K256, 4'd1,  128'h1f352c073b6108d72d9810a30914dff4, 53, 4'd14};
      vecs[6] = '{2'd1, K192, 4'd1,  128'h62f8ead2522c6b7bfe0c91f72402f5a5, 47, 4'd12};
      bus.start = 1'b0; bus.keySize = 2'd0; bus.keyIn = '0; bus.roundIdx = 4'd0;
      rstN = 1'b0;
      tick(); tick();
      chk("rst_ready", bus.ready, 1); chk("rst_busy", bus.busy, 0);
      chk("rst_kv", bus.keysValid, 0); chk("rst_err", bus.err, 0);
      chk("rst_nr", bus.numRounds, 0); chk("rst_rk", bus.roundKey, 0);
      chk("rst_rkv", bus.roundKeyValid, 0);
      rstN = 1'b1;
      tick();
      bus.roundIdx = 4'd11;
      #1 chk("idle_idx11_rkv", bus.roundKeyValid, 0);
      for (int i = 0; i < 7; i++) begin
         run(vecs[i].ks, vecs[i].key, lat);
         chk($sformatf("vec%0d_lat", i), lat, vecs[i].lat);
         chk($sformatf("vec%0d_nr", i), bus.numRounds, vecs[i].nr);
         bus.roundIdx = vecs[i].ridx;
         #1;
         chk($sformatf("vec%0d_rkv", i), bus.roundKeyValid, 1);
         chk($sformatf("vec%0d_rk", i), bus.roundKey, vecs[i].rk);
      end
      // early read of round 2 while generating
      bus.roundIdx = 4'd2; bus.keySize = 2'd0; bus.keyIn = K128; bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      chk("early_busy", bus.busy, 1); chk("early_ready", bus.ready, 0);
      chk("early_rkv_at_accept", bus.roundKeyValid, 0);
      n = 0;
      while (!bus.roundKeyValid && n < 100) begin tick(); n++; end
      chk("early_rise_cycle", n, 8);
      chk("early_rk2", bus.roundKey, 128'hf2c295f27a96b9435935807a7359f67f);
      while (!bus.keysValid && n < 100) begin tick(); n++; end
      // round 11 never valid for AES-128, through GEN and DONE
      bus.roundIdx = 4'd11; bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      hits = 0; n = 0;
      while (!bus.keysValid && n < 100) begin if (bus.roundKeyValid) hits++; tick(); n++; end
      repeat (3) begin if (bus.roundKeyValid) hits++; tick(); end
      chk("idx11_hits", hits, 0);
      // illegal mode in DONE
      bus.keySize = 2'd3; bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      chk("ill_err", bus.err, 1); chk("ill_kv", bus.keysValid, 1);
      chk("ill_nr", bus.numRounds, 10); chk("ill_ready", bus.ready, 1);
      tick();
      chk("ill_err_pulse", bus.err, 0);
      // start pulse while busy is ignored
      bus.roundIdx = 4'd10; bus.keySize = 2'd0; bus.keyIn = K128; bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      n = 0;
      while (!bus.keysValid && n < 200) begin
         bus.start = n == 5; bus.keySize = n == 5 ? 2'd2 : 2'd0; bus.keyIn = K256;
         tick();
         n++;
         if (n == 6) chk("busy_start_err", bus.err, 0);
      end
      bus.start = 1'b0;
      chk("busy_start_lat", n, 41); chk("busy_start_nr", bus.numRounds, 10);
      chk("busy_start_rk10", bus.roundKey, R128_10);
      // reset in the middle of generation
      bus.roundIdx = 4'd0; bus.keySize = 2'd0; bus.keyIn = K128; bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      repeat (20) tick();
      chk("mid_busy_before", bus.busy, 1);
      rstN = 1'b0;
      tick();
      chk("mid_ready", bus.ready, 1); chk("mid_busy", bus.busy, 0);
      chk("mid_kv", bus.keysValid, 0); chk("mid_err", bus.err, 0);
      chk("mid_nr", bus.numRounds, 0); chk("mid_rk", bus.roundKey, 0);
      chk("mid_rkv", bus.roundKeyValid, 0);
      rstN = 1'b1;
      tick();
      run(2'd0, K128, lat);
      chk("post_rst_lat", lat, 41);
      bus.roundIdx = 4'd10;
      #1 chk("post_rst_rk10", bus.roundKey, R128_10);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/key_expansion_seq.md
Name: key_expansion_seq

Overview:
- Sequential, multi-mode AES key schedule generator.
- Expands a 128, 192 or 256-bit cipher key, selected at run time, into round keys at one 32-bit word per clock.
- Stores all round keys internally and serves them through an indexed 128-bit read port.
- Sits beside the round datapath and replaces the fully unrolled combinational expander where area matters.

Parameters:
- MAX_KEY_BITS, 256, largest supported key size: 128, 192 or 256. Sets storage depth to 44, 52 or 60 words. Modes above this size are rejected.
- READ_REG, 0, 0 = combinational round-key read; 1 = registered read with 1-cycle latency.

Ports:
- clk  in  1  system clock. Single clock domain.
- rstN  in  1  reset, synchronous and active-low.
- start  in  1  request to begin an expansion.
- keySize  in  2  0 = AES-128, 1 = AES-192, 2 = AES-256, 3 = illegal.
- keyIn  in  256  cipher key, left-aligned. The key occupies keyIn[255 -: Nk*32]; unused LSBs are ignored.
- ready  out  1  high in IDLE or DONE, meaning start will be accepted.
- busy  out  1  high while words are being generated.
- keysValid  out  1  level; every round key of the last accepted key is stored.
- err  out  1  one-cycle pulse when start is rejected.
- numRounds  out  4  Nr of the last accepted mode: 10, 12 or 14. Reset value 0.
- roundIdx  in  4  round key to read, 0..Nr.
- roundKey  out  128  words w[4*roundIdx .. 4*roundIdx+3], first word in the MSBs.
- roundKeyValid  out  1  requested round key is already written and roundIdx <= Nr.

Behaviour:
- Reset values:
  - FSM returns to IDLE.
  - ready=1; busy, keysValid, err = 0; numRounds=0; roundKey=0; roundKeyValid=0.
  - Storage contents are don't-care.
- States and transitions:
  - IDLE: waits for start. Goes to GEN on an accepted start.
  - GEN: writes one word per cycle. Goes to DONE after the final word.
  - DONE: holds keysValid. Goes to GEN on an accepted start.
- Accepting start (start=1 and ready=1 on a clock edge):
  - keySize 0/1/2 gives Nk = 4/6/8 and Nr = 10/12/14.
  - On that edge: words w[0..Nk-1] are written from keyIn; wordCnt=Nk; phase=0; rcon=0x01; numRounds=Nr; keysValid=0; state goes to GEN.
- Rejecting start:
  - keySize=3, or a mode wider than MAX_KEY_BITS, pulses err for 1 cycle.
  - State, keysValid and numRounds are unchanged.
- start while busy: ignored, no err.
- Each GEN cycle writes w[i] with i = wordCnt, temp = w[i-1], phase = i mod Nk:
  - phase==0: temp = SubWord(RotWord(temp)) ^ {rcon, 24'h0}, then rcon = xtime(rcon) (0x80 becomes 0x1b).
  - Nk==8 and phase==4: temp = SubWord(temp).
  - w[i] = w[i-Nk] ^ temp.
  - wordCnt and phase (wrapping at Nk-1) increment. No divider is used.
- Completion:
  - The final word i = 4*Nr+3 is written in GEN.
  - Next cycle the state is DONE: keysValid=1, busy=0, ready=1.
- Latency from the accept edge to keysValid high: 4*(Nr+1)-Nk+1 cycles, i.e. 41 / 47 / 53.
- Read port:
  - roundKeyValid = (roundIdx <= numRounds) and (wordCnt >= 4*roundIdx+4).
  - Early rounds may be read during GEN.
  - With READ_REG=1, roundKey and roundKeyValid lag roundIdx by 1 cycle.
  - When roundKeyValid=0, roundKey is don't-care but must not carry X from uninitialised storage; it drives 0.
- rstN low mid-GEN: back to IDLE, the partial schedule is discarded, keysValid=0.
- keyIn is sampled only at the accept edge. Later changes have no effect.

Decomposition:
- Shared package: keySize encodings, Nk/Nr lookup constants, state enum, word-count width, and an xtime function.
- Sub-module key_word_gen (combinational): inputs prevWord, nkAgoWord, phase, nk, rcon; output newWord.
- key_word_gen instantiates the existing SBox four times.

Test Plan:
- AES-128, key 2b7e151628aed2a6abf7158809cf4f3c:
  - keysValid rises 41 cycles after accept.
  - roundIdx=1 gives a0fafe1788542cb123a339392a6c7605.
  - roundIdx=10 gives d014f9a8c9ee2589e13f0cc8b6630ca6.
- AES-192, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b:
  - numRounds=12.
  - roundIdx=12 gives e98ba06f448c773c8ecc720401002202 after 47 cycles.
- AES-256, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4:
  - roundIdx=14 gives fe4890d1e6188d0b046df344706c631e after 53 cycles.
  - Confirms the phase-4 SubWord path.
- Early read: during AES-128 GEN, hold roundIdx=2.
  - roundKeyValid goes 0→1 exactly when w[11] is written.
  - roundIdx=11 yields roundKeyValid=0 in every state.
- Illegal mode and busy start:
  - start with keySize=3 in DONE gives a 1-cycle err; keysValid stays 1.
  - start pulses during GEN are ignored and the result is unchanged.
- Reset mid-operation: drop rstN at cycle 20 of GEN.
  - All outputs return to reset values.
  - A subsequent AES-128 run produces correct round keys.
